// File: rtl/posit_unit_ctrl_if.sv
// Handshake and posit-unit bundle for posit_unit_ctrl.
// slave is the controller view, master the requester/unit-model view.
interface posit_unit_ctrl_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [1:0]  req_op_i;
  logic [15:0] req_a_i;
  logic [15:0] req_b_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [15:0] rsp_result_o;
  logic        rsp_inf_o;
  logic        rsp_zero_o;
  logic        rsp_err_o;
  logic        pu_start_o;
  logic [1:0]  pu_op_sel_o;
  logic [15:0] pu_in1_o;
  logic [15:0] pu_in2_o;
  logic [15:0] pu_out_i;
  logic        pu_inf_i;
  logic        pu_zero_i;
  logic        pu_done_i;
  logic [15:0] op_count_o;

  modport slave (
    input  req_valid_i, req_op_i, req_a_i, req_b_i,
    input  rsp_ready_i,
    input  pu_out_i, pu_inf_i, pu_zero_i, pu_done_i,
    output req_ready_o,
    output rsp_valid_o, rsp_result_o,
    output rsp_inf_o, rsp_zero_o, rsp_err_o,
    output pu_start_o, pu_op_sel_o,
    output pu_in1_o, pu_in2_o,
    output op_count_o
  );

  modport master (
    output req_valid_i, req_op_i, req_a_i, req_b_i,
    output rsp_ready_i,
    output pu_out_i, pu_inf_i, pu_zero_i, pu_done_i,
    input  req_ready_o,
    input  rsp_valid_o, rsp_result_o,
    input  rsp_inf_o, rsp_zero_o, rsp_err_o,
    input  pu_start_o, pu_op_sel_o,
    input  pu_in1_o, pu_in2_o,
    input  op_count_o
  );
endinterface

// File: rtl/posit_unit_ctrl.sv
// Valid/ready front-end for the 16-bit posit add/mul/div unit.
// Issues one op, waits for done (or times out), returns a registered response.
module posit_unit_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned MIN_WAIT       = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  posit_unit_ctrl_if.slave bus
);

  localparam logic [15:0] NAR    = 16'h8000;
  localparam logic [7:0]  TO_END = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]  MIN_W  = 8'(MIN_WAIT);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  state_t     state;
  logic [7:0] cnt;
  logic       done_ok;

  assign bus.req_ready_o = (state == IDLE);
  // early done pulses belong to the previous op
  assign done_ok = bus.pu_done_i && (cnt >= MIN_W);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state            <= IDLE;
      cnt              <= '0;
      bus.rsp_valid_o  <= 1'b0;
      bus.rsp_result_o <= '0;
      bus.rsp_inf_o    <= 1'b0;
      bus.rsp_zero_o   <= 1'b0;
      bus.rsp_err_o    <= 1'b0;
      bus.pu_start_o   <= 1'b0;
      bus.pu_op_sel_o  <= '0;
      bus.pu_in1_o     <= '0;
      bus.pu_in2_o     <= '0;
      bus.op_count_o   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.req_valid_i) begin
            if (bus.req_op_i == 2'b11) begin
              bus.rsp_valid_o  <= 1'b1;
              bus.rsp_result_o <= NAR;
              bus.rsp_inf_o    <= 1'b0;
              bus.rsp_zero_o   <= 1'b0;
              bus.rsp_err_o    <= 1'b1;
              state            <= RESP;
            end else begin
              bus.pu_op_sel_o <= bus.req_op_i;
              bus.pu_in1_o    <= bus.req_a_i;
              bus.pu_in2_o    <= bus.req_b_i;
              bus.pu_start_o  <= 1'b1;
              cnt             <= '0;
              state           <= BUSY;
            end
          end
        end
        BUSY: begin
          if (cnt != 8'hFF) cnt <= cnt + 8'd1;
          if (done_ok) begin
            bus.rsp_valid_o  <= 1'b1;
            bus.rsp_result_o <= bus.pu_out_i;
            bus.rsp_inf_o    <= bus.pu_inf_i;
            bus.rsp_zero_o   <= bus.pu_zero_i;
            bus.rsp_err_o    <= 1'b0;
            bus.pu_start_o   <= 1'b0;
            state            <= RESP;
          end else if (cnt == TO_END) begin
            bus.rsp_valid_o  <= 1'b1;
            bus.rsp_result_o <= NAR;
            bus.rsp_inf_o    <= 1'b1;
            bus.rsp_zero_o   <= 1'b0;
            bus.rsp_err_o    <= 1'b1;
            bus.pu_start_o   <= 1'b0;
            state            <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready_i) begin
            bus.rsp_valid_o <= 1'b0;
            bus.op_count_o  <= bus.op_count_o + 16'd1;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_posit_unit_ctrl.sv
// Randomized bench for posit_unit_ctrl against a transaction-level model.
// Covers add, stale done, illegal op, timeout, backpressure, reset, wrap.
module tb_posit_unit_ctrl;

  localparam int TO = 8;
  localparam int MW = 1;

  logic clk;
  logic rst_n;
  int   errs;
  int   checks;
  logic [15:0] cnt_model;

  posit_unit_ctrl_if bus ();

  posit_unit_ctrl #(
    .TIMEOUT_CYCLES(TO),
    .MIN_WAIT(MW)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_start"}, 32'(bus.pu_start_o), 0);
    chk({tag, "_valid"}, 32'(bus.rsp_valid_o), 0);
    chk({tag, "_ready"}, 32'(bus.req_ready_o), 1);
    chk({tag, "_res"}, 32'(bus.rsp_result_o), 0);
    chk({tag, "_flags"},
        32'({bus.rsp_inf_o, bus.rsp_zero_o, bus.rsp_err_o}), 0);
    chk({tag, "_opsel"}, 32'(bus.pu_op_sel_o), 0);
    chk({tag, "_in"}, {bus.pu_in1_o, bus.pu_in2_o}, 0);
    chk({tag, "_cnt"}, 32'(bus.op_count_o), 0);
  endtask

  // One transaction; called and returns on a negedge.
  // done_at: first BUSY cycle index with done high (>= TO means never).
  task automatic run_op(input logic [1:0]  op,
                        input logic [15:0] a,
                        input logic [15:0] b,
                        input logic [15:0] out,
                        input logic        inf,
                        input logic        zero,
                        input int          done_at,
                        input bit          stale,
                        input int          bp,
                        input bit          hold_req);
    int jstar, e_lat, e_starts, lat, starts, bad, w, l;
    logic [15:0] e_res;
    logic [2:0]  e_flags;
    jstar = -1;
    for (int j = MW; j < TO; j++)
      if (jstar < 0 && (stale || j >= done_at)) jstar = j;
    if (op == 2'b11) begin
      e_lat = 1; e_res = 16'h8000; e_flags = 3'b001; e_starts = 0;
    end else if (jstar >= 0) begin
      e_lat = jstar + 2; e_res = out; e_flags = {inf, zero, 1'b0};
      e_starts = jstar + 1;
    end else begin
      e_lat = TO + 1; e_res = 16'h8000; e_flags = 3'b101; e_starts = TO;
    end
    w = 0;
    while (!bus.req_ready_o && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("req_ready", 32'(bus.req_ready_o), 1);
    bus.req_valid_i = 1'b1;
    bus.req_op_i    = op;
    bus.req_a_i     = a;
    bus.req_b_i     = b;
    bus.pu_out_i    = out;
    bus.pu_inf_i    = inf;
    bus.pu_zero_i   = zero;
    bus.pu_done_i   = stale;
    @(posedge clk);
    lat = 0; starts = 0; bad = 0; l = 1;
    while (l <= TO + 4) begin
      @(negedge clk);
      bus.req_valid_i = 1'b0;
      if (bus.rsp_valid_o) begin
        lat = l;
        break;
      end
      if (bus.pu_start_o) begin
        starts++;
        if (bus.pu_in1_o != a || bus.pu_in2_o != b
            || bus.pu_op_sel_o != op) bad++;
      end
      bus.pu_done_i = stale || ((l - 1) >= done_at);
      @(posedge clk);
      l++;
    end
    chk("latency", 32'(lat), 32'(e_lat));
    chk("start_cycles", 32'(starts), 32'(e_starts));
    chk("operands_held", 32'(bad), 0);
    bus.rsp_ready_i = 1'b0;
    for (int i = 0; i < bp; i++) begin
      if (hold_req) begin
        bus.req_valid_i = 1'b1;
        bus.req_op_i    = 2'b11;
      end
      chk("bp_res", 32'(bus.rsp_result_o), 32'(e_res));
      chk("bp_ready", 32'(bus.req_ready_o), 0);
      chk("bp_valid", 32'(bus.rsp_valid_o), 1);
      @(posedge clk);
      @(negedge clk);
    end
    chk("rsp_valid", 32'(bus.rsp_valid_o), 1);
    chk("rsp_result", 32'(bus.rsp_result_o), 32'(e_res));
    chk("rsp_flags",
        32'({bus.rsp_inf_o, bus.rsp_zero_o, bus.rsp_err_o}),
        32'(e_flags));
    bus.rsp_ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready_i = 1'b0;
    cnt_model++;
    chk("op_count", 32'(bus.op_count_o), 32'(cnt_model));
    chk("post_valid", 32'(bus.rsp_valid_o), 0);
    chk("post_ready", 32'(bus.req_ready_o), 1);
    chk("post_start", 32'(bus.pu_start_o), 0);
    if (op != 2'b11)
      chk("in_kept", {bus.pu_in1_o, bus.pu_in2_o}, {a, b});
    if (hold_req) begin
      @(posedge clk);
      @(negedge clk);
      bus.req_valid_i = 1'b0;
      chk("bp_accept", 32'(bus.rsp_valid_o), 1);
      chk("bp_err", 32'(bus.rsp_err_o), 1);
      bus.rsp_ready_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.rsp_ready_i = 1'b0;
      cnt_model++;
      chk("bp_count", 32'(bus.op_count_o), 32'(cnt_model));
    end
  endtask

  task automatic reset_mid(input bit in_resp, input string tag);
    bus.req_valid_i = 1'b1;
    bus.req_op_i    = in_resp ? 2'b11 : 2'b10;
    bus.req_a_i     = 16'h1234;
    bus.req_b_i     = 16'h5678;
    bus.pu_done_i   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    chk({tag, "_pre"}, 32'(in_resp ? bus.rsp_valid_o : bus.pu_start_o), 1);
    #2 rst_n = 1'b0;
    #1 chk_idle_outputs(tag);
    @(negedge clk);
    rst_n = 1'b1;
    cnt_model = '0;
  endtask

  initial begin
    errs = 0;
    checks = 0;
    cnt_model = '0;
    rst_n = 1'b0;
    bus.req_valid_i = 1'b0;
    bus.req_op_i = '0;
    bus.req_a_i = '0;
    bus.req_b_i = '0;
    bus.rsp_ready_i = 1'b0;
    bus.pu_out_i = '0;
    bus.pu_inf_i = 1'b0;
    bus.pu_zero_i = 1'b0;
    bus.pu_done_i = 1'b0;
    repeat (2) @(negedge clk);
    chk_idle_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    run_op(2'b00, 16'h4000, 16'h4000, 16'h4800, 0, 0, 2, 0, 0, 0);
    run_op(2'b01, 16'h3000, 16'h5000, 16'h4400, 0, 0, 0, 1, 0, 0);
    run_op(2'b11, 16'h1111, 16'h2222, 16'h0000, 0, 0, 0, 0, 0, 0);
    run_op(2'b10, 16'h4000, 16'h0000, 16'h2222, 0, 1, 99, 0, 0, 0);
    run_op(2'b10, 16'h4000, 16'h3000, 16'h4aaa, 0, 0, TO - 1, 0, 0, 0);
    run_op(2'b00, 16'h0001, 16'h0002, 16'h0003, 0, 0, 1, 0, 5, 1);

    for (int n = 0; n < 60; n++)
      run_op(2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom),
             16'($urandom), 1'($urandom), 1'($urandom),
             int'($urandom_range(0, 10)), ($urandom_range(0, 3) == 0),
             int'($urandom_range(0, 3)), 0);

    reset_mid(0, "rst_busy");
    run_op(2'b00, 16'h4000, 16'h4000, 16'h4800, 0, 0, 2, 0, 0, 0);
    reset_mid(1, "rst_resp");
    run_op(2'b00, 16'h4000, 16'h4000, 16'h4800, 0, 0, 2, 0, 0, 0);

    force bus.op_count_o = 16'hFFFE;
    #1 release bus.op_count_o;
    cnt_model = 16'hFFFE;
    @(negedge clk);
    run_op(2'b11, 16'h0, 16'h0, 16'h0, 0, 0, 0, 0, 0, 0);
    run_op(2'b01, 16'h4000, 16'h4000, 16'h4000, 0, 0, 3, 0, 1, 0);
    chk("wrap", 32'(bus.op_count_o), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
